fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle instruction-fetch controller for the ARMv8 core. Owns the architectural PC register, issues one instruction-memory read per instruction over a valid/ready request with a valid-only response, presents the fetched word to decode/execute, and waits for execute to retire it. Once execute retires the instruction, it selects PC+4 or the taken-branch target from the branch controls.

## Interface
Parameters:
- PC_W, 64, PC and address width
- CNT_W, 32, retired-instruction counter width

Ports:
- CLK  in  1  clock, rising edge
- resetl  in  1  asynchronous active-low reset
- startpc  in  PC_W  PC loaded on first cycle after reset release
- Stall  in  1  hold before next fetch
- ImemReqValid  out  1  fetch request valid
- ImemReqReady  in  1  memory accepts request
- ImemAddr  out  PC_W  fetch address (equals CurrentPC)
- ImemRspValid  in  1  response data valid
- ImemRspData  in  32  fetched instruction
- Instruction  out  32  registered instruction to decode
- InstrValid  out  1  Instruction valid, awaiting retire
- ExecDone  in  1  execute retires Instruction; branch inputs valid this cycle
- Branch  in  1  conditional branch (CBZ-type)
- Uncondbranch  in  1  unconditional branch
- ALUZero  in  1  ALU zero flag
- SignExtImm64  in  64  sign-extended byte offset
- CurrentPC  out  PC_W  PC of instruction in flight
- InstrCount  out  CNT_W  retired instructions, wraps
- Fault  out  1  misaligned target trap (see Configuration)

## Operation
- States: IDLE, FETCH, WAIT, EXEC, HOLD, FAULT.
- IDLE: CurrentPC <= startpc; -> FETCH.
- FETCH: ImemReqValid=1; on ImemReqReady -> WAIT.
- WAIT: on ImemRspValid, Instruction <= ImemRspData; -> EXEC.
- EXEC: InstrValid=1; on ExecDone: InstrCount++, CurrentPC <= target; -> HOLD if Stall, else FETCH.
- HOLD: -> FETCH when Stall=0.
- Target: taken = (Branch & ALUZero) | Uncondbranch; taken ? CurrentPC+SignExtImm64 : CurrentPC+4. Offset is bytes, not shifted. Both sums modulo 2^PC_W, wrap silently.
- Stall only acts at EXEC exit and in HOLD; never withdraws an asserted request.
- ImemRspValid ignored outside WAIT; ExecDone and branch inputs ignored outside EXEC.

## Timing
- Reset values: CurrentPC=0, Instruction=0, InstrCount=0, ImemReqValid=0, InstrValid=0, Fault=0, state IDLE.
- Reset asserted mid-operation: immediate return to reset values; any outstanding response is dropped (IDLE ignores it).
- Best case 3 cycles per instruction: FETCH with Ready=1, WAIT with RspValid=1, EXEC with ExecDone=1. First request appears 1 cycle after reset release.
- Handshake: ImemReqValid and ImemAddr held stable until ImemReqReady=1; transfer happens in the cycle where both are 1. Response comes at earliest in the cycle after acceptance.
- InstrValid and Instruction are registered; high from the first EXEC cycle until the ExecDone cycle inclusive.
- CurrentPC updates the cycle after ExecDone; ImemAddr follows it in the same cycle.
- InstrCount wraps from all-ones to 0.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: at ExecDone, if target[1:0]!=0, CurrentPC is not updated, InstrCount still increments, Fault <= 1, state -> FAULT. FAULT is terminal until reset; no further requests.
- Undefined: no check; Fault tied 0; FAULT state unreachable.

## Structure
- Package fetch_pkg: state enum, PC_INC constant (4), INSTR_W constant (32).
- One combinational sub-module, pc_target_calc: computes target from CurrentPC, SignExtImm64, Branch, ALUZero, Uncondbranch. The FSM, registers and counter stay in the top.

## Test plan
- Reset release with startpc=0x1000, Ready=Rsp=ExecDone=1 every cycle, no branches -> ImemAddr 0x1000, 0x1004, 0x1008 at 3-cycle spacing; InstrCount=3 after third retire.
- ExecDone with Branch=1, ALUZero=1, SignExtImm64=-8, PC=0x2010 -> next ImemAddr 0x2008; repeat with ALUZero=0 -> 0x2014; Uncondbranch=1, imm=0x40 -> 0x2050.
- Ready held low 5 cycles -> ImemReqValid and ImemAddr stable throughout; spurious ImemRspValid in FETCH ignored.
- Stall=1 at ExecDone for 4 cycles -> no request for 4 cycles, request in cycle after Stall drops; PC=0xFFFF_FFFF_FFFF_FFFC with no branch -> wraps to 0.
- resetl pulsed low while in WAIT -> outputs at reset values at once; late ImemRspValid ignored; fetch restarts at startpc.
- With FETCH_ALIGN_CHECK_EN, Uncondbranch with imm=0x6 -> Fault=1, CurrentPC unchanged, no further ImemReqValid until reset.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Sequencer states; FAULT is only reachable with FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HOLD  = 3'd4,
        FAULT = 3'd5
    } state_e;

    // Sequential PC advance in bytes (one A64 instruction)
    localparam int unsigned PC_INC  = 4;
    // Instruction word width
    localparam int unsigned INSTR_W = 32;

endpackage

// File: rtl/fetch_sequencer_pc_target_calc.sv
// Next-PC selection: PC+4, or PC+byte offset when the branch is taken.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; result is only consumed when execute retires.
module pc_target_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] cur_pc_i,
    input  logic [63:0]     imm_i,
    input  logic            branch_i,
    input  logic            zero_i,
    input  logic            uncond_i,
    output logic [PC_W-1:0] target_o
);

    logic taken;

    // CBZ-style conditional taken on zero, or unconditional; offset is in bytes
    // and both sums wrap modulo 2^PC_W.
    assign taken    = (branch_i & zero_i) | uncond_i;
    assign target_o = taken ? (cur_pc_i + imm_i[PC_W-1:0])
                            : (cur_pc_i + PC_W'(PC_INC));

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, fetches one word, waits for retire.
// Latency: best case 3 cycles per instruction (FETCH, WAIT, EXEC).
// Backpressure: request held stable until ImemReqReady; Stall holds before next fetch.
// Optional misaligned-target trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic [PC_W-1:0]     startpc,
    input  logic                Stall,
    output logic                ImemReqValid,
    input  logic                ImemReqReady,
    output logic [PC_W-1:0]     ImemAddr,
    input  logic                ImemRspValid,
    input  logic [INSTR_W-1:0]  ImemRspData,
    output logic [INSTR_W-1:0]  Instruction,
    output logic                InstrValid,
    input  logic                ExecDone,
    input  logic                Branch,
    input  logic                Uncondbranch,
    input  logic                ALUZero,
    input  logic [63:0]         SignExtImm64,
    output logic [PC_W-1:0]     CurrentPC,
    output logic [CNT_W-1:0]    InstrCount,
    output logic                Fault
);

    state_e               state_q;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 req_vld_q;
    logic                 instr_vld_q;
    logic                 fault_q;
    logic                 align_err;

    pc_target_calc #(
        .PC_W (PC_W)
    ) u_pc_target_calc (
        .cur_pc_i (pc_q),
        .imm_i    (SignExtImm64),
        .branch_i (Branch),
        .zero_i   (ALUZero),
        .uncond_i (Uncondbranch),
        .target_o (pc_d)
    );

    // Retire counter simply wraps at all-ones
    assign cnt_d = cnt_q + CNT_W'(1);

`ifdef FETCH_ALIGN_CHECK_EN
    // Any target not on a 4-byte boundary traps instead of being fetched
    assign align_err = |pc_d[1:0];
`else
    assign align_err = 1'b0;
`endif

    // Sequencer FSM with all outputs registered
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            cnt_q       <= '0;
            req_vld_q   <= 1'b0;
            instr_vld_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_q      <= startpc;
                    req_vld_q <= 1'b1;
                    state_q   <= FETCH;
                end
                FETCH: begin
                    // Request stays up, address frozen, until accepted
                    if (ImemReqReady) begin
                        req_vld_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (ImemRspValid) begin
                        instr_q     <= ImemRspData;
                        instr_vld_q <= 1'b1;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (ExecDone) begin
                        instr_vld_q <= 1'b0;
                        cnt_q       <= cnt_d;
                        if (align_err) begin
                            // PC left pointing at the trapping instruction
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else begin
                            pc_q <= pc_d;
                            if (Stall) begin
                                state_q <= HOLD;
                            end else begin
                                req_vld_q <= 1'b1;
                                state_q   <= FETCH;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        req_vld_q <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ImemReqValid = req_vld_q;
    assign ImemAddr     = pc_q;
    assign CurrentPC    = pc_q;
    assign Instruction  = instr_q;
    assign InstrValid   = instr_vld_q;
    assign InstrCount   = cnt_q;
    assign Fault        = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboarded fetch addresses and retired words.
// Latency: n/a. Backpressure: exercised via ImemReqReady and Stall.
// Misaligned-trap checks follow FETCH_ALIGN_CHECK_EN.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startpc;
    logic        Stall;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [63:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        ExecDone;
    logic        Branch;
    logic        Uncondbranch;
    logic        ALUZero;
    logic [63:0] SignExtImm64;
    logic [63:0] CurrentPC;
    logic [31:0] InstrCount;
    logic        Fault;

    fetch_sequencer #(.PC_W(64), .CNT_W(32)) dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .startpc      (startpc),
        .Stall        (Stall),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .ExecDone     (ExecDone),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUZero      (ALUZero),
        .SignExtImm64 (SignExtImm64),
        .CurrentPC    (CurrentPC),
        .InstrCount   (InstrCount),
        .Fault        (Fault)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_hs = 0;

    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: compare each accepted request and each retired word
    always @(negedge CLK) begin
        if (resetl === 1'b1 && ImemReqValid === 1'b1 && ImemReqReady === 1'b1) begin
            if (exp_addr_q.size() == 0) chk("unexpected_req", ImemAddr, 64'hFFFF_FFFF_FFFF_FFFF);
            else                        chk("fetch_addr", ImemAddr, exp_addr_q.pop_front());
        end
        if (resetl === 1'b1 && InstrValid === 1'b1 && ExecDone === 1'b1) begin
            if (exp_instr_q.size() == 0) chk("unexpected_retire", {32'h0, Instruction}, 64'hFFFF_FFFF);
            else                         chk("retired_instr", {32'h0, Instruction}, {32'h0, exp_instr_q.pop_front()});
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        Stall = 0; ImemReqReady = 0; ImemRspValid = 0; ImemRspData = 0;
        ExecDone = 0; Branch = 0; Uncondbranch = 0; ALUZero = 0; SignExtImm64 = 0;
    endtask

    task automatic do_reset(input logic [63:0] spc);
        resetl = 0;
        clear_inputs();
        startpc = spc;
        step(); step();
        chk("rst_req_vld",     ImemReqValid, 0);
        chk("rst_pc",          CurrentPC, 0);
        chk("rst_instr",       Instruction, 0);
        chk("rst_instr_vld",   InstrValid, 0);
        chk("rst_count",       InstrCount, 0);
        chk("rst_fault",       Fault, 0);
        resetl = 1;
        step();
        chk("first_req_vld",   ImemReqValid, 1);
        chk("first_req_addr",  ImemAddr, spc);
    endtask

    task automatic wait_req;
        int n = 0;
        while (ImemReqValid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (ImemReqValid !== 1'b1) chk("req_timeout", ImemReqValid, 1);
    endtask

    // One full instruction: request (optionally held off), response, retire
    task automatic do_instr(input logic [63:0] addr, input logic [31:0] data, input int rdy_dly,
                            input logic br, input logic z, input logic ub,
                            input logic [63:0] imm, input int stall);
        exp_addr_q.push_back(addr);
        wait_req();
        for (int i = 0; i < rdy_dly; i++) begin
            ImemReqReady = 0;
            ImemRspValid = 1;
            ImemRspData  = 32'hDEAD_0000 | i;
            step();
            chk("req_held",  ImemReqValid, 1);
            chk("addr_held", ImemAddr, addr);
        end
        ImemReqReady = 1;
        ImemRspValid = 0;
        last_hs = cyc;
        step();
        ImemReqReady = 0;
        ImemRspValid = 1;
        ImemRspData  = data;
        exp_instr_q.push_back(data);
        step();
        ImemRspValid = 0;
        ImemRspData  = 32'h0BAD_0BAD;
        chk("instr_vld_exec", InstrValid, 1);
        ExecDone = 1; Branch = br; ALUZero = z; Uncondbranch = ub; SignExtImm64 = imm;
        Stall = (stall > 0);
        chk("pc_before_retire", CurrentPC, addr);
        step();
        ExecDone = 0; Branch = 0; ALUZero = 0; Uncondbranch = 0; SignExtImm64 = 0;
        chk("instr_vld_clr", InstrValid, 0);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                chk("stall_noreq", ImemReqValid, 0);
                step();
            end
            Stall = 0;
            chk("stall_drop_noreq", ImemReqValid, 0);
            step();
            chk("req_after_stall", ImemReqValid, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2;
        resetl = 0;
        startpc = 0;
        clear_inputs();

        // Straight-line best-case fetch from 0x1000
        do_reset(64'h1000);
        do_instr(64'h1000, 32'hAA00_0001, 0, 0, 0, 0, 64'h0, 0); c0 = last_hs;
        do_instr(64'h1004, 32'hAA00_0002, 0, 0, 0, 0, 64'h0, 0); c1 = last_hs;
        do_instr(64'h1008, 32'hAA00_0003, 0, 0, 0, 0, 64'h0, 0); c2 = last_hs;
        chk("spacing_1", 64'(c1 - c0), 3);
        chk("spacing_2", 64'(c2 - c1), 3);
        chk("count_3", InstrCount, 3);
        chk("pc_after_3", CurrentPC, 64'h100C);

        // Conditional taken, backward offset; then a held-off request
        do_reset(64'h2010);
        do_instr(64'h2010, 32'hBB00_0001, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        chk("cbz_taken_pc", CurrentPC, 64'h2008);
        do_instr(64'h2008, 32'hBB00_0002, 5, 0, 0, 0, 64'h0, 0);
        chk("pc_after_held", CurrentPC, 64'h200C);

        // Conditional not taken
        do_reset(64'h2010);
        do_instr(64'h2010, 32'hCC00_0001, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        chk("cbz_not_taken_pc", CurrentPC, 64'h2014);

        // Unconditional forward branch
        do_reset(64'h2010);
        do_instr(64'h2010, 32'hDD00_0001, 0, 0, 0, 1, 64'h40, 0);
        chk("uncond_pc", CurrentPC, 64'h2050);
        do_instr(64'h2050, 32'hDD00_0002, 0, 0, 0, 0, 64'h0, 0);

        // PC wrap at top of address space, with a 4-cycle stall
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        do_instr(64'hFFFF_FFFF_FFFF_FFFC, 32'hEE00_0001, 0, 0, 0, 0, 64'h0, 4);
        chk("wrap_pc", CurrentPC, 64'h0);
        do_instr(64'h0, 32'hEE00_0002, 0, 0, 0, 0, 64'h0, 0);
        chk("count_after_wrap", InstrCount, 2);

        // Reset pulsed while waiting for a response
        do_reset(64'h3000);
        do_instr(64'h3000, 32'hFF00_0001, 0, 0, 0, 0, 64'h0, 0);
        exp_addr_q.push_back(64'h3004);
        wait_req();
        ImemReqReady = 1;
        step();
        ImemReqReady = 0;
        #2;
        resetl = 0;
        #1;
        chk("midrst_pc",        CurrentPC, 0);
        chk("midrst_req_vld",   ImemReqValid, 0);
        chk("midrst_count",     InstrCount, 0);
        chk("midrst_instr_vld", InstrValid, 0);
        ImemRspValid = 1;
        ImemRspData  = 32'h5555_AAAA;
        step();
        resetl = 1;
        step();
        ImemRspValid = 0;
        chk("late_rsp_instr",     Instruction, 0);
        chk("late_rsp_instr_vld", InstrValid, 0);
        chk("restart_req_vld",    ImemReqValid, 1);
        chk("restart_addr",       ImemAddr, 64'h3000);
        do_instr(64'h3000, 32'hFF00_0002, 0, 0, 0, 0, 64'h0, 0);
        chk("restart_count", InstrCount, 1);

        // Misaligned branch target
        do_reset(64'h4000);
        do_instr(64'h4000, 32'h1100_0001, 0, 0, 0, 1, 64'h6, 0);
        chk("misalign_count", InstrCount, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_fault", Fault, 1);
        chk("misalign_pc", CurrentPC, 64'h4000);
        for (int i = 0; i < 8; i++) begin
            ImemReqReady = 1;
            chk("fault_noreq", ImemReqValid, 0);
            step();
        end
        ImemReqReady = 0;
        do_reset(64'h5000);
`else
        chk("misalign_fault", Fault, 0);
        chk("misalign_pc", CurrentPC, 64'h4006);
`endif

        chk("addr_q_drained",  exp_addr_q.size(), 0);
        chk("instr_q_drained", exp_instr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
